// File: rtl/bus_arbiter_sys.sv
// bus_arbiter_sys: fixed-priority, non-preemptive two-master arbiter whose grants
// select one of two small register-file peripherals on a shared bus.
module bus_arbiter_sys #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req1,
  input  logic              req2,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              grant1,
  output logic              grant2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, G1, G2} state_e;
  state_e state_q, state_d;
  logic [1:0] gnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  // the current owner keeps the bus while it requests; otherwise hand over with no idle cycle
  always_comb begin
    state_d = IDLE;
    case (state_q)
      G1:      state_d = req1 ? G1 : req2 ? G2 : IDLE;
      G2:      state_d = req2 ? G2 : req1 ? G1 : IDLE;
      default: state_d = req1 ? G1 : req2 ? G2 : IDLE;
    endcase
  end
  assign gnt    = {state_q == G2, state_q == G1};
  assign grant1 = gnt[0];
  assign grant2 = gnt[1];
  for (genvar g = 0; g < 2; g++) begin : g_per
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              we, re;
    assign we = wr_en & gnt[g];
    assign re = rd_en & gnt[g];
    // read samples mem_q before the same-edge write lands, so rd+wr returns old data
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        rdata_q <= '0;
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
        if (re) rdata_q <= mem_q[addr];
        if (we) mem_q[addr] <= wdata;
      end
  end
  assign rdata1 = g_per[0].rdata_q;
  assign rdata2 = g_per[1].rdata_q;
endmodule

// File: tb/tb_bus_arbiter_sys.sv
// tb_bus_arbiter_sys: directed vector table for arbitration and peripheral access,
// plus hand-written reset and mid-write reset sequences.
module tb_bus_arbiter_sys;
  logic       clk = 0, rst = 0, req1 = 0, req2 = 0, wr_en = 0, rd_en = 0;
  logic [1:0] addr = 0;
  logic [3:0] wdata = 0;
  logic       grant1, grant2;
  logic [3:0] rdata1, rdata2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  bus_arbiter_sys #(.DATA_W(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .grant1(grant1), .grant2(grant2),
    .rdata1(rdata1), .rdata2(rdata2)
  );

  typedef struct {
    logic       q1, q2, w, r;
    logic [1:0] a;
    logic [3:0] d;
    logic       g1, g2;
    logic [3:0] r1, r2;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(input logic q1, q2, w, r, input int a, d,
                              input logic g1, g2, input int r1, r2);
    vec_t x;
    x.q1 = q1; x.q2 = q2; x.w = w; x.r = r;
    x.a = a[1:0]; x.d = d[3:0];
    x.g1 = g1; x.g2 = g2; x.r1 = r1[3:0]; x.r2 = r2[3:0];
    return x;
  endfunction

  task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic chk_all(input string n, input logic g1, g2, input logic [3:0] r1, r2);
    chk({n, " grant1"}, {3'b0, grant1}, {3'b0, g1});
    chk({n, " grant2"}, {3'b0, grant2}, {3'b0, g2});
    chk({n, " rdata1"}, rdata1, r1);
    chk({n, " rdata2"}, rdata2, r2);
  endtask

  initial begin
    //             q1 q2 w  r  a  d    g1 g2 r1   r2
    v.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0,   0));    // idle after reset
    v.push_back(mk(1, 0, 1, 0, 3, 5,   1, 0, 0,   0));    // strobe with request: no effect
    v.push_back(mk(1, 0, 1, 0, 0, 'hA, 1, 0, 0,   0));    // P1 mem0 = A
    v.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0,   0));    // drop req1
    v.push_back(mk(0, 1, 0, 0, 0, 0,   0, 1, 0,   0));
    v.push_back(mk(0, 1, 1, 0, 1, 'hC, 0, 1, 0,   0));    // P2 mem1 = C
    v.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0,   0));
    v.push_back(mk(1, 1, 0, 0, 0, 0,   1, 0, 0,   0));    // contention: req1 wins
    v.push_back(mk(1, 1, 1, 0, 2, 'hF, 1, 0, 0,   0));    // P1 mem2 = F
    v.push_back(mk(0, 1, 0, 0, 0, 0,   0, 1, 0,   0));    // handover, no idle
    v.push_back(mk(1, 1, 0, 0, 0, 0,   0, 1, 0,   0));    // non-preemptive
    v.push_back(mk(1, 1, 0, 1, 1, 0,   0, 1, 0,   'hC));
    v.push_back(mk(1, 0, 0, 0, 0, 0,   1, 0, 0,   'hC));  // handover back to req1
    v.push_back(mk(1, 0, 0, 1, 2, 0,   1, 0, 'hF, 'hC));
    v.push_back(mk(1, 0, 0, 1, 3, 0,   1, 0, 0,   'hC));  // early strobe left mem3 = 0
    v.push_back(mk(1, 0, 0, 1, 0, 0,   1, 0, 'hA, 'hC));
    v.push_back(mk(1, 0, 0, 1, 1, 0,   1, 0, 0,   'hC));  // P1 mem1 untouched by P2 write
    v.push_back(mk(1, 0, 0, 1, 0, 0,   1, 0, 'hA, 'hC));
    v.push_back(mk(1, 0, 0, 0, 1, 0,   1, 0, 'hA, 'hC));  // rdata holds
    v.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 'hA, 'hC));
    v.push_back(mk(0, 0, 1, 1, 0, 3,   0, 0, 'hA, 'hC));  // strobes without grant
    v.push_back(mk(0, 1, 0, 0, 0, 0,   0, 1, 'hA, 'hC));
    v.push_back(mk(0, 1, 0, 1, 0, 0,   0, 1, 'hA, 0));    // P2 mem0 never written
    v.push_back(mk(0, 1, 0, 1, 1, 0,   0, 1, 'hA, 'hC));
    v.push_back(mk(0, 1, 1, 1, 1, 6,   0, 1, 'hA, 'hC));  // rd+wr: old data
    v.push_back(mk(0, 1, 0, 1, 1, 0,   0, 1, 'hA, 6));    // new data stored
    v.push_back(mk(1, 0, 0, 0, 0, 0,   1, 0, 'hA, 6));
    v.push_back(mk(1, 0, 0, 1, 0, 0,   1, 0, 'hA, 6));    // ungranted write left mem0 = A

    repeat (5) @(posedge clk);
    #1 chk_all("reset", 0, 0, 0, 0);
    @(negedge clk) rst = 1;

    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      req1 = v[i].q1; req2 = v[i].q2; wr_en = v[i].w; rd_en = v[i].r;
      addr = v[i].a; wdata = v[i].d;
      @(posedge clk);
      #1 chk_all($sformatf("v%0d", i), v[i].g1, v[i].g2, v[i].r1, v[i].r2);
    end

    // reset mid-write: asynchronous clear, write lost
    @(negedge clk);
    req1 = 1; rd_en = 0; wr_en = 1; addr = 0; wdata = 9;
    #2 rst = 0;
    #1 chk_all("async rst", 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_all("rst held", 0, 0, 0, 0);
    @(negedge clk) begin rst = 1; wr_en = 0; end
    @(posedge clk);
    #1 chk_all("regrant", 1, 0, 0, 0);
    @(negedge clk) rd_en = 1;
    @(posedge clk);
    #1 chk_all("mem cleared", 1, 0, 0, 0);
    @(negedge clk) addr = 2;
    @(posedge clk);
    #1 chk_all("mem2 cleared", 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_sys.md
# bus_arbiter_sys

Two-master, two-target bus subsystem: a fixed-priority, non-preemptive arbiter grants one of two requesters access to a shared write/read bus. Each grant line selects one of two identical small register-file peripherals. The block sits between two bus masters sharing one address/data/strobe bundle and their local storage, and exposes per-peripheral read data.

## Interface
Parameters:
- DATA_W, 4, peripheral word width
- ADDR_W, 2, address width; each peripheral holds 2^ADDR_W words

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately; release is synchronous to clk)
- req1  input  1  bus request from requester 1 (higher priority)
- req2  input  1  bus request from requester 2
- wr_en  input  1  shared write strobe
- rd_en  input  1  shared read strobe
- addr  input  ADDR_W  shared word address
- wdata  input  DATA_W  shared write data
- grant1  output  1  registered grant to requester 1; enables peripheral 1
- grant2  output  1  registered grant to requester 2; enables peripheral 2
- rdata1  output  DATA_W  registered read data of peripheral 1
- rdata2  output  DATA_W  registered read data of peripheral 2

## Operation
- Arbiter states: IDLE (no grant), G1 (grant1=1), G2 (grant2=1). grant1 and grant2 are never both 1.
- IDLE: req1=1 -> G1; else req2=1 -> G2; else stay IDLE.
- G1: stay while req1=1; on req1=0 go to G2 if req2=1, else IDLE.
- G2: stay while req2=1 (non-preemptive; req1 does not interrupt). On req2=0 go to G1 if req1=1, else IDLE.
- Peripheral i effective strobes: we_i = wr_en & granti, re_i = rd_en & granti. The ungranted peripheral ignores the bus entirely.
- Peripheral storage: 2^ADDR_W x DATA_W registers, all cleared to 0 on reset.
- Write: on a rising edge with we_i=1, mem[addr] <= wdata.
- Read: on a rising edge with re_i=1, rdata_i <= mem[addr]. rdata_i holds its value when re_i=0.
- we_i and re_i together at the same address: rdata_i returns the pre-write (old) value, and the write still commits.
- Addresses wrap naturally within ADDR_W bits; no out-of-range case exists.

## Timing
- Reset values: grant1=0, grant2=0, rdata1=0, rdata2=0, arbiter state IDLE, all memory words 0.
- Asserting reset mid-transfer aborts it immediately: grants drop, rdata and memory clear, and an in-flight write is lost.
- Grant latency: one cycle. A request sampled high at edge N gives the grant high after edge N. A request dropped at edge N gives the grant low after edge N.
- Handover: when the owner drops its request while the other requester is waiting, the grant switches on that same edge with no idle cycle.
- Write latency: the value is stored at the edge where wr_en & granti is sampled, and is readable from the next cycle.
- Read latency: rdata_i updates one edge after rd_en & granti is sampled.
- Strobes asserted without a grant, or in the same cycle as the request, have no effect.

## Test plan
- Reset: hold rst=0 for 5 cycles -> grants=0, rdata1=rdata2=0000. Release rst -> still all 0 with no requests.
- P1 write: req1=1, wait 1 cycle (grant1=1), then wr_en=1, addr=00, wdata=1010 for 1 cycle -> P1 mem[0]=1010, P2 unchanged. Drop req1 -> grant1=0 next cycle.
- P2 write: req2=1, then wr_en=1, addr=01, wdata=1100 -> grant2=1 only, P2 mem[1]=1100, P1 mem[1] stays 0000.
- Contention: req1=req2=1 from IDLE -> grant1=1, grant2=0. Write addr=10, wdata=1111 lands only in P1. Drop req1 while holding req2 -> grant2=1 on the next edge. Repeat starting with G2 held and raise req1 -> grant2 is kept (non-preemptive).
- Reads: req1, rd_en=1, addr=10 -> rdata1=1111 one cycle later. req2, rd_en=1, addr=01 -> rdata2=1100. Each rdata holds after rd_en drops, and the other peripheral's rdata is unchanged.
- Edge cases: wr_en with no grant -> no memory change. Simultaneous rd+wr at the same address -> old data returned, new data stored. Reset asserted mid-write -> grant and memory cleared.
